// File: rtl/slow_bus_stretcher.sv
// CPU bus-cycle sequencer: derives PHI_2 / CPU_CE from a 16-CLK frame and stretches
// cycles that touch 1 MHz peripherals so PHI_2 high lines up with PERIPH_PHI_2 high.
//
// state   | meaning
// --------+-----------------------------------------------------------
// FAST    | normal 8-CLK cycle, PHI_2 = cnt[2]
// WAIT_LO | slow access seen, holding PHI_2 low until PERIPH_PHI_2 rises
// SLOW_HI | PHI_2 high for the full 1 MHz high phase (cnt 8..15)
module slow_bus_stretcher #(
    parameter logic [4:0] SLOW_MASK = 5'b11110,
    parameter int         CNT_W     = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             nACIA,
    input  logic             nADLC,
    input  logic             nFDC,
    input  logic             nADC,
    input  logic             nTUBE,
    input  logic             HALT,
    output logic             PHI_2,
    output logic             PERIPH_PHI_2,
    output logic             CPU_CE,
    output logic             STRETCH,
    output logic [CNT_W-1:0] SLOW_COUNT
);

    typedef enum logic [1:0] {
        FAST    = 2'd0,
        WAIT_LO = 2'd1,
        SLOW_HI = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       slow;
    logic       count_inc;
    logic       phi2_nxt, ce_nxt, stretch_nxt;

    assign slow = |(~{nACIA, nADLC, nFDC, nADC, nTUBE} & SLOW_MASK);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt   <= 4'd0;
            state <= FAST;
        end else begin
            cnt   <= cnt_nxt;
            state <= state_nxt;
        end
    end

    // Outputs are registered from the next-period values, so each output
    // belongs to the CLK period in which cnt holds the matching count.
    always_comb begin
        cnt_nxt     = cnt + 4'd1;
        state_nxt   = state;
        count_inc   = 1'b0;
        phi2_nxt    = 1'b0;
        ce_nxt      = 1'b0;
        stretch_nxt = 1'b0;

        case (state)
            FAST: begin
                if (cnt[2:0] == 3'd3 && slow) begin
                    state_nxt = WAIT_LO;
                    count_inc = 1'b1;
                end
            end
            WAIT_LO: if (cnt == 4'd7)  state_nxt = SLOW_HI;
            SLOW_HI: if (cnt == 4'd15) state_nxt = FAST;
            default: state_nxt = FAST;
        endcase

        case (state_nxt)
            FAST: begin
                phi2_nxt = cnt_nxt[2];
                ce_nxt   = (cnt_nxt[2:0] == 3'd7) && !HALT;
            end
            WAIT_LO: stretch_nxt = 1'b1;
            SLOW_HI: begin
                phi2_nxt    = 1'b1;
                stretch_nxt = 1'b1;
                ce_nxt      = (cnt_nxt == 4'd15) && !HALT;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PHI_2        <= 1'b0;
            PERIPH_PHI_2 <= 1'b0;
            CPU_CE       <= 1'b0;
            STRETCH      <= 1'b0;
            SLOW_COUNT   <= '0;
        end else begin
            PHI_2        <= phi2_nxt;
            PERIPH_PHI_2 <= cnt_nxt[3];
            CPU_CE       <= ce_nxt;
            STRETCH      <= stretch_nxt;
            if (count_inc && SLOW_COUNT != {CNT_W{1'b1}})
                SLOW_COUNT <= SLOW_COUNT + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_slow_bus_stretcher.sv
// Scoreboard bench for slow_bus_stretcher: a phase-counting reference model predicts
// every output period; a monitor compares after each rising edge.
module tb_slow_bus_stretcher;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] nsel = 5'b11111;   // {ACIA, ADLC, FDC, ADC, TUBE}
    logic       halt = 1'b0;
    logic       phi_2, periph_phi_2, cpu_ce, stretch;
    logic [7:0] slow_count;

    int checks = 0;
    int errors = 0;
    int pushes = 0;
    int pops   = 0;

    logic [11:0] exp_q[$];

    // Reference model: current period count plus remaining low / high stretch periods.
    int m_cnt   = 0;
    int lo_left = 0;
    int hi_left = 0;
    int m_count = 0;

    slow_bus_stretcher dut (
        .CLK          (clk),
        .RESET        (rst),
        .nACIA        (nsel[4]),
        .nADLC        (nsel[3]),
        .nFDC         (nsel[2]),
        .nADC         (nsel[1]),
        .nTUBE        (nsel[0]),
        .HALT         (halt),
        .PHI_2        (phi_2),
        .PERIPH_PHI_2 (periph_phi_2),
        .CPU_CE       (cpu_ce),
        .STRETCH      (stretch),
        .SLOW_COUNT   (slow_count)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic [4:0] s, input logic h, input logic r);
        logic e_phi, e_per, e_ce, e_str;
        bit   is_slow;
        if (r) begin
            m_cnt = 0; lo_left = 0; hi_left = 0; m_count = 0;
            exp_q.push_back(12'd0);
            pushes++;
            return;
        end
        is_slow = (s[4] == 1'b0) || (s[3] == 1'b0) || (s[2] == 1'b0) || (s[1] == 1'b0);
        if (lo_left == 0 && hi_left == 0 && (m_cnt % 8) == 3 && is_slow) begin
            lo_left = (m_cnt == 3) ? 4 : 12;
            hi_left = 8;
            if (m_count < 255) m_count++;
        end
        m_cnt = (m_cnt + 1) % 16;
        e_per = (m_cnt >= 8);
        if (lo_left > 0) begin
            lo_left--;
            e_phi = 1'b0; e_str = 1'b1; e_ce = 1'b0;
        end else if (hi_left > 0) begin
            hi_left--;
            e_phi = 1'b1; e_str = 1'b1; e_ce = (hi_left == 0) && !h;
        end else begin
            e_phi = ((m_cnt % 8) >= 4); e_str = 1'b0; e_ce = ((m_cnt % 8) == 7) && !h;
        end
        exp_q.push_back({e_phi, e_per, e_ce, e_str, 8'(m_count)});
        pushes++;
    endtask

    task automatic cycle(input logic [4:0] s, input logic h, input logic r);
        logic was_rst;
        @(negedge clk);
        was_rst = rst;
        nsel = s; halt = h; rst = r;
        if (r && !was_rst) begin
            #1;
            checks++;
            if ({phi_2, periph_phi_2, cpu_ce, stretch, slow_count} !== 12'd0) begin
                errors++;
                $display("FAIL reset_immediate: got %b %b %b %b %0d, want all zero",
                         phi_2, periph_phi_2, cpu_ce, stretch, slow_count);
            end
        end
        model_step(s, h, r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(5'b11111, 1'b0, 1'b0);
    endtask

    task automatic run_until(input int c);
        for (int i = 0; i < 64 && m_cnt != c; i++) cycle(5'b11111, 1'b0, 1'b0);
    endtask

    // Monitor: one expected entry per rising edge once stimulus has started.
    initial begin
        logic [11:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {phi_2, periph_phi_2, cpu_ce, stretch, slow_count};
                pops++;
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard @%0t: got phi2=%b per=%b ce=%b str=%b cnt=%0d, want phi2=%b per=%b ce=%b str=%b cnt=%0d",
                             $time, a[11], a[10], a[9], a[8], a[7:0], e[11], e[10], e[9], e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] s;
        logic       h;
        logic       r;

        for (int i = 0; i < 3; i++) cycle(5'b11111, 1'b0, 1'b1);
        idle(21);
        cycle(5'b11111, 1'b0, 1'b1);
        cycle(5'b11111, 1'b0, 1'b1);
        idle(20);

        run_until(3);
        cycle(5'b01111, 1'b0, 1'b0);
        idle(20);

        run_until(11);
        cycle(5'b11101, 1'b0, 1'b0);
        idle(30);

        for (int i = 0; i < 40; i++) cycle(5'b11110, 1'b0, 1'b0);

        run_until(0);
        for (int i = 0; i < 24; i++) cycle(5'b11111, 1'b1, 1'b0);
        idle(16);

        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 5; b++) s[b] = ($urandom_range(0, 9) != 0);
            h = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 299) == 0);
            cycle(s, h, r);
        end
        idle(16);

        run_until(3);
        cycle(5'b10111, 1'b0, 1'b0);
        idle(6);
        cycle(5'b11111, 1'b0, 1'b1);
        idle(10);

        for (int i = 0; i < 300 * 16 + 32; i++) cycle(5'b00000, 1'b0, 1'b0);
        idle(2);
        @(negedge clk);
        checks++;
        if (slow_count !== 8'd255) begin
            errors++;
            $display("FAIL saturation: got %0d, want 255", slow_count);
        end

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || pops != pushes) begin
            errors++;
            $display("FAIL drain: got %0d pops of %0d pushes, want all", pops, pushes);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
